// File: rtl/demux_stream_if.sv
// demux_stream_if: stream bundle for the registered 1-to-2 demultiplexer.
// Carries the input valid/ready stream with its select bit and the two output
// valid/ready streams. "master" is the environment side (producer driving the
// input, consumers driving the output readies); "slave" is the demux side.
interface demux_stream_if #(
    parameter int WIDTH = 8
) ();
    // input stream
    logic [WIDTH-1:0] in_data;
    logic             in_sel;
    logic             in_valid;
    logic             in_ready;

    // output port 1
    logic [WIDTH-1:0] out1_data;
    logic             out1_valid;
    logic             out1_ready;

    // output port 2
    logic [WIDTH-1:0] out2_data;
    logic             out2_valid;
    logic             out2_ready;

    modport master (
        output in_data,
        output in_sel,
        output in_valid,
        input  in_ready,
        input  out1_data,
        input  out1_valid,
        output out1_ready,
        input  out2_data,
        input  out2_valid,
        output out2_ready
    );

    modport slave (
        input  in_data,
        input  in_sel,
        input  in_valid,
        output in_ready,
        output out1_data,
        output out1_valid,
        input  out1_ready,
        output out2_data,
        output out2_valid,
        input  out2_ready
    );
endinterface

// File: rtl/demux_stream.sv
// demux_stream: registered 1-to-2 stream demultiplexer.
// Each accepted input word is steered by in_sel (1 -> out1, 0 -> out2) into a
// single-entry output buffer. Each buffer is a two-state EMPTY/FULL machine
// that can drain and reload on the same edge, so a port streams one word per
// cycle while its consumer holds ready high. A stalled port never blocks
// traffic addressed to the other port. cnt1/cnt2 count completed output
// handshakes modulo 256.
// Optional feature macro: DEMUX_DEC_EN -- when defined the stored word is
// in_data - 1 (wrapping), undoing the +1 applied on the transmit side.
module demux_stream #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    demux_stream_if.slave       bus,
    output logic [7:0]          cnt1,
    output logic [7:0]          cnt2
);

    // Port index 0 is out1 (selected by in_sel=1), index 1 is out2 (in_sel=0).
    localparam int NPORTS = 2;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } port_state_t;

    logic [WIDTH-1:0]             stored_word;
    logic [NPORTS-1:0]            ready_vec;
    logic [NPORTS-1:0]            free_vec;
    logic [NPORTS-1:0]            load_vec;
    logic [NPORTS-1:0]            valid_vec;
    logic [NPORTS-1:0][WIDTH-1:0] data_vec;
    logic [NPORTS-1:0][7:0]       cnt_vec;
    logic                         accept;

    // Word written into a buffer; the optional decrement sits ahead of the
    // buffer register so it costs no latency.
`ifdef DEMUX_DEC_EN
    assign stored_word = bus.in_data - WIDTH'(1);
`else
    assign stored_word = bus.in_data;
`endif

    assign ready_vec = {bus.out2_ready, bus.out1_ready};

    // A buffer can take a word this cycle if it is empty or is being drained
    // on the same edge; in_ready follows whichever port is selected.
    assign bus.in_ready = bus.in_sel ? free_vec[0] : free_vec[1];
    assign accept       = bus.in_valid && bus.in_ready;
    assign load_vec[0]  = accept && bus.in_sel;
    assign load_vec[1]  = accept && !bus.in_sel;

    generate
        for (genvar gi = 0; gi < NPORTS; gi++) begin : g_port
            port_state_t      state_reg;
            port_state_t      state_next;
            logic [WIDTH-1:0] data_reg;
            logic [WIDTH-1:0] data_next;
            logic [7:0]       cnt_reg;
            logic [7:0]       cnt_next;
            logic             drain;

            // Output handshake on this port.
            assign drain = (state_reg == ST_FULL) && ready_vec[gi];

            assign free_vec[gi]  = (state_reg == ST_EMPTY) || ready_vec[gi];
            assign valid_vec[gi] = (state_reg == ST_FULL);
            assign data_vec[gi]  = data_reg;
            assign cnt_vec[gi]   = cnt_reg;

            // Next state: load takes precedence over drain so a simultaneous
            // drain+load keeps the buffer full with the new word.
            always_comb begin
                state_next = state_reg;
                data_next  = data_reg;
                cnt_next   = cnt_reg;
                if (drain) begin
                    cnt_next = cnt_reg + 8'd1;
                end
                case (state_reg)
                    ST_EMPTY: begin
                        if (load_vec[gi]) begin
                            state_next = ST_FULL;
                            data_next  = stored_word;
                        end
                    end
                    ST_FULL: begin
                        if (load_vec[gi]) begin
                            data_next = stored_word;
                        end else if (ready_vec[gi]) begin
                            state_next = ST_EMPTY;
                        end
                    end
                    default: begin
                        state_next = ST_EMPTY;
                    end
                endcase
            end

            // Buffer, state and counter registers; reset discards the word
            // and suppresses any handshake on the same edge.
            always_ff @(posedge clk) begin
                if (rst) begin
                    state_reg <= ST_EMPTY;
                    data_reg  <= '0;
                    cnt_reg   <= 8'd0;
                end else begin
                    state_reg <= state_next;
                    data_reg  <= data_next;
                    cnt_reg   <= cnt_next;
                end
            end
        end
    endgenerate

    assign bus.out1_valid = valid_vec[0];
    assign bus.out1_data  = data_vec[0];
    assign bus.out2_valid = valid_vec[1];
    assign bus.out2_data  = data_vec[1];
    assign cnt1           = cnt_vec[0];
    assign cnt2           = cnt_vec[1];

endmodule

// File: tb/tb_demux_stream.sv
// tb_demux_stream: directed scenarios plus randomized traffic for demux_stream,
// checked each cycle against a transaction-level model built from two
// depth-1 queues and two transfer tallies.
module tb_demux_stream;

    localparam int WIDTH = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] cnt1;
    logic [7:0] cnt2;

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    logic [7:0] q1[$];
    logic [7:0] q2[$];
    int         tally1 = 0;
    int         tally2 = 0;

    demux_stream_if #(.WIDTH(WIDTH)) bus ();

    demux_stream #(.WIDTH(WIDTH)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus.slave),
        .cnt1 (cnt1),
        .cnt2 (cnt2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] stored(input logic [7:0] d);
`ifdef DEMUX_DEC_EN
        return d - 8'd1;
`else
        return d;
`endif
    endfunction

    // One clock cycle: drive at negedge, check in_ready, advance the model on
    // the rising edge, then check every output against the model.
    task automatic step(input logic v, input logic s, input logic [7:0] d,
                        input logic r1, input logic r2, input logic do_rst,
                        output logic acc);
        logic exp_ready;
        @(negedge clk);
        rst            = do_rst;
        bus.in_valid   = v;
        bus.in_sel     = s;
        bus.in_data    = d;
        bus.out1_ready = r1;
        bus.out2_ready = r2;
        exp_ready = s ? (q1.size() == 0 || r1) : (q2.size() == 0 || r2);
        #1;
        check("in_ready", 32'(bus.in_ready), 32'(exp_ready));
        acc = v && exp_ready && !do_rst;
        @(posedge clk);
        if (do_rst) begin
            q1.delete();
            q2.delete();
            tally1 = 0;
            tally2 = 0;
        end else begin
            if (q1.size() != 0 && r1) begin
                void'(q1.pop_front());
                tally1++;
            end
            if (q2.size() != 0 && r2) begin
                void'(q2.pop_front());
                tally2++;
            end
            if (acc) begin
                if (s) q1.push_back(stored(d));
                else   q2.push_back(stored(d));
            end
        end
        #1;
        check("out1_valid", 32'(bus.out1_valid), 32'(q1.size() != 0));
        check("out2_valid", 32'(bus.out2_valid), 32'(q2.size() != 0));
        if (q1.size() != 0) check("out1_data", 32'(bus.out1_data), 32'(q1[0]));
        if (q2.size() != 0) check("out2_data", 32'(bus.out2_data), 32'(q2[0]));
        check("cnt1", 32'(cnt1), 32'(tally1 % 256));
        check("cnt2", 32'(cnt2), 32'(tally2 % 256));
        $display("cyc v=%0b sel=%0b d=%02h r=%0b%0b rst=%0b acc=%0b | o1=%0b:%02h o2=%0b:%02h c=%0d/%0d",
                 v, s, d, r1, r2, do_rst, acc, bus.out1_valid, bus.out1_data,
                 bus.out2_valid, bus.out2_data, cnt1, cnt2);
    endtask

    initial begin
        logic       acc;
        logic       pend;
        logic       ps;
        logic [7:0] pd;
        logic [7:0] exp_dec;

        bus.in_valid = 1'b0; bus.in_sel = 1'b0; bus.in_data = '0;
        bus.out1_ready = 1'b0; bus.out2_ready = 1'b0;

        // reset and release
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, acc);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, acc);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, acc);
        check("rst_out1_data", 32'(bus.out1_data), 32'h0);
        check("rst_out2_data", 32'(bus.out2_data), 32'h0);
        check("rst_in_ready", 32'(bus.in_ready), 32'h1);

        // single word to out1, then its handshake
        step(1'b1, 1'b1, 8'h3C, 1'b1, 1'b1, 1'b0, acc);
        check("first_out1_data", 32'(bus.out1_data), 32'(stored(8'h3C)));
        step(1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, acc);
        check("first_cnt1", 32'(cnt1), 32'd1);

        // backpressure on out2, then drain+load on the same edge
        step(1'b1, 1'b0, 8'h11, 1'b1, 1'b0, 1'b0, acc);
        step(1'b1, 1'b0, 8'h22, 1'b1, 1'b0, 1'b0, acc);
        check("bp_blocked", 32'(acc), 32'h0);
        step(1'b1, 1'b0, 8'h22, 1'b1, 1'b1, 1'b0, acc);
        check("bp_reload", 32'(bus.out2_data), 32'(stored(8'h22)));
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, acc);

        // out1 stalled full; out2 still accepts
        step(1'b1, 1'b1, 8'h77, 1'b0, 1'b1, 1'b0, acc);
        step(1'b1, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0, acc);
        check("indep_accept", 32'(acc), 32'h1);
        check("indep_out1_hold", 32'(bus.out1_data), 32'(stored(8'h77)));
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, acc);

        // streaming 300 words to out1 from a clean counter
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, acc);
        for (int i = 0; i < 300; i++) begin
            step(1'b1, 1'b1, 8'(i), 1'b1, 1'b1, 1'b0, acc);
        end
        step(1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, acc);
        check("stream_cnt1_wrap", 32'(cnt1), 32'd44);

        // decrement boundary
`ifdef DEMUX_DEC_EN
        exp_dec = 8'hFF;
`else
        exp_dec = 8'h00;
`endif
        step(1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, acc);
        check("dec_zero", 32'(bus.out1_data), 32'(exp_dec));
        step(1'b1, 1'b0, 8'h3D, 1'b1, 1'b1, 1'b0, acc);
        check("dec_3d", 32'(bus.out2_data), 32'(stored(8'h3D)));

        // reset mid-operation with both ports full and stalled
        step(1'b1, 1'b1, 8'h12, 1'b0, 1'b0, 1'b0, acc);
        step(1'b1, 1'b0, 8'h34, 1'b0, 1'b0, 1'b0, acc);
        step(1'b1, 1'b1, 8'h56, 1'b1, 1'b1, 1'b1, acc);
        check("midrst_v1", 32'(bus.out1_valid), 32'h0);
        check("midrst_c2", 32'(cnt2), 32'h0);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, acc);
        check("midrst_not_captured", 32'(bus.out1_valid), 32'h0);

        // randomized traffic; producer holds sel/data while a word is pending
        pend = 1'b0; ps = 1'b0; pd = '0;
        for (int i = 0; i < 3000; i++) begin
            logic v;
            if (!pend) begin
                ps = 1'($urandom_range(0, 1));
                pd = 8'($urandom);
            end
            v = pend ? 1'b1 : ($urandom_range(0, 9) < 7);
            step(v, ps, pd, ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 6),
                 ($urandom_range(0, 499) == 0), acc);
            pend = v && !acc;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/demux_stream.md
# demux_stream

Registered 1-to-2 stream demultiplexer: the receive-side counterpart of the increment-then-select path. It accepts one 8-bit valid/ready stream plus a select bit and steers each word into one of two single-entry output buffers, each with its own valid/ready handshake. An optional decrement stage removes the +1 applied on the transmit side. Per-output transfer counters support bring-up and debug.

## Interface
- WIDTH, 8, data width of input and both outputs
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- in_data  input  WIDTH  input word
- in_sel  input  1  destination: 1 → out1, 0 → out2 (same polarity as the transmit-side mux)
- in_valid  input  1  in_data/in_sel valid
- in_ready  output  1  block can accept this cycle
- out1_data  output  WIDTH  port 1 word (registered)
- out1_valid  output  1  port 1 buffer full
- out1_ready  input  1  port 1 consumer accepts
- out2_data  output  WIDTH  port 2 word (registered)
- out2_valid  output  1  port 2 buffer full
- out2_ready  input  1  port 2 consumer accepts
- cnt1  output  8  completed port 1 transfers, mod 256
- cnt2  output  8  completed port 2 transfers, mod 256

## Operation
- Each output port is a 2-state machine: EMPTY (outN_valid=0) and FULL (outN_valid=1).
- in_ready is combinational: in_sel ? (!out1_valid || out1_ready) : (!out2_valid || out2_ready). in_ready may depend on in_sel; the producer must hold in_sel stable while in_valid=1.
- Accept occurs when in_valid && in_ready. The selected port then loads at the next edge: outN_data ← stored value, outN_valid ← 1. The other port is unaffected.
- Output handshake occurs when outN_valid && outN_ready. On that edge outN_valid → 0 unless a new word loads into the same port in the same cycle.
- Simultaneous drain and load on the same port: valid stays 1, data is replaced by the new word, and the counter increments. No bubble occurs and no word is lost.
- FULL with outN_ready=0 holds outN_data and outN_valid stable. If that port is selected, in_ready=0.
- A stall on one port never blocks traffic selected to the other port.
- cntN increments by 1 on each port-N output handshake and wraps 255 → 0.
- Stored value is in_data by default. With decrement enabled (see Configuration), stored value is (in_data − 1) mod 2^WIDTH.

## Timing
- Reset values: out1_data=0, out2_data=0, out1_valid=0, out2_valid=0, cnt1=0, cnt2=0. in_ready is therefore 1 after reset.
- Latency: 1 cycle from input accept to outN_valid=1.
- Throughput: 1 word/cycle per port while the consumer holds ready=1.
- rst takes priority over all handshakes in the same cycle. Buffered words are discarded, and no counter increments on the reset edge.
- in_valid=0 never changes state. Data presented without an accept is ignored.

## Configuration
- DEMUX_DEC_EN
  - Defined: the stored word is in_data − 1 with WIDTH-bit wraparound (0x00 → 0xFF). The decrement is combinational ahead of the buffer register and adds no latency.
  - Undefined: the stored word is in_data unchanged and the subtractor is not synthesised.

## Test plan
- Reset, then release: all outputs 0 and in_ready=1. Send in_data=0x3C with in_sel=1 and out1_ready=1 → next cycle out1_data=0x3C, out1_valid=1, and out2_valid stays 0. cnt1=1 on the following edge.
- Backpressure: out2_ready=0; send 0x11 then 0x22 with in_sel=0 → out2 holds 0x11 and in_ready=0 for the second word. Raise out2_ready → 0x11 transfers, 0x22 loads on the same edge, and cnt2 increments.
- Independent ports: out1 stalled and full; send 0xA5 with in_sel=0 → accepted, out2_data=0xA5 one cycle later, and out1 unchanged.
- Streaming: 300 back-to-back words to out1 with out1_ready=1 → one word per cycle with no bubbles, and cnt1 wraps to 44 (300 mod 256).
- DEMUX_DEC_EN defined: in_data 0x00 → out 0xFF, and 0x3D → 0x3C. Undefined: 0x00 → 0x00.
- Reset mid-operation: both ports FULL and stalled; assert rst for 1 cycle with in_valid=1 and both ready=1 → both valid=0, both counters 0, and the input word is not captured.
